// File: rtl/iq_issue_ctrl_pkg.sv
// Shared constants for the issue queue: geometry, payload opcodes and the
// packed slot-word layout used by the control and payload halves.
package iq_issue_ctrl_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_IW    = 3;
  localparam int IQ_NREG  = 32;
  localparam int IQ_RW    = 5;

  // Opcodes the payload storage decodes to choose rd or rs2 as its second register field.
  localparam logic [3:0] OP_ALU    = 4'h0;
  localparam logic [3:0] OP_ALUI   = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h4;

  localparam int SLOT_VALID_BIT = 0;
  localparam int SLOT_V1_BIT    = 1;
  localparam int SLOT_P1_BIT    = 2;
  localparam int SLOT_SRC1_LSB  = 3;
  localparam int SLOT_V2_BIT    = SLOT_SRC1_LSB + IQ_RW;
  localparam int SLOT_P2_BIT    = SLOT_V2_BIT + 1;
  localparam int SLOT_SRC2_LSB  = SLOT_P2_BIT + 1;
  localparam int SLOT_VDEST_BIT = SLOT_SRC2_LSB + IQ_RW;
  localparam int SLOT_DEST_LSB  = SLOT_VDEST_BIT + 1;
  localparam int SLOT_W         = SLOT_DEST_LSB + IQ_RW;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-ready picker: rotate the ready vector so head sits at bit 0,
// take the lowest set bit, then add head back to get the slot index.
module iq_age_select
  import iq_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int IW    = IQ_IW
) (
  input  logic [DEPTH-1:0] ready,
  input  logic [IW-1:0]    head,
  output logic             any,
  output logic [IW-1:0]    sel
);

  logic [DEPTH-1:0] rot;
  logic [IW-1:0]    off;

  always_comb begin
    rot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rot[k] = ready[head + IW'(k)];
    end
    off = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    any = |rot;
    sel = head + off;
  end

endmodule

// File: rtl/iq_issue_ctrl.sv
// Issue-queue control: slot allocation, register busy table, source wakeup
// and oldest-ready selection; the payload storage follows alloc_slot/issue_slot.
module iq_issue_ctrl
  import iq_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int IW    = IQ_IW,
  parameter int NREG  = IQ_NREG,
  parameter int RW    = IQ_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          d_valid,
  input  logic          d_v1,
  input  logic [RW-1:0] d_src1,
  input  logic          d_v2,
  input  logic [RW-1:0] d_src2,
  input  logic          d_vdest,
  input  logic [RW-1:0] d_dest,
  output logic          d_ready,
  output logic [IW-1:0] alloc_slot,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_dest,
  input  logic          e_stall,
  output logic          issue_valid,
  output logic [IW-1:0] issue_slot,
  output logic          cheio,
  output logic          vazio
);

  logic [IW-1:0]    head, tail;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] v1, p1, v2, p2;
  logic [RW-1:0]    src1 [DEPTH];
  logic [RW-1:0]    src2 [DEPTH];
  logic [NREG-1:0]  busy;

  logic [DEPTH-1:0] ready;
  logic             any;
  logic [IW-1:0]    sel;
  logic             dispatch, do_issue, wb_hit, set_dest;
  logic             d_p1, d_p2;

  // A dispatching source is pending only if its register is busy and not
  // being written back in this very cycle; r0 is hard-wired ready.
  function automatic logic src_pending(input logic used, input logic [RW-1:0] src,
                                       input logic [NREG-1:0] bt, input logic wbv,
                                       input logic [RW-1:0] wbd);
    return used && bt[src] && !(wbv && (wbd == src)) && (src != '0);
  endfunction

  assign cheio      = (head == tail) && valid[head];
  assign vazio      = ~|valid;
  assign d_ready    = !cheio && !flush;
  assign alloc_slot = tail;

  assign dispatch = d_valid && d_ready;
  assign wb_hit   = wb_valid && (wb_dest != '0);
  assign set_dest = dispatch && d_vdest && (d_dest != '0);
  assign d_p1     = src_pending(d_v1, d_src1, busy, wb_valid, wb_dest);
  assign d_p2     = src_pending(d_v2, d_src2, busy, wb_valid, wb_dest);

  assign ready    = valid & ~(v1 & p1) & ~(v2 & p2);
  assign do_issue = any && !e_stall && !flush;

  iq_age_select #(.DEPTH(DEPTH), .IW(IW)) u_age_select (
    .ready (ready),
    .head  (head),
    .any   (any),
    .sel   (sel)
  );

  // Control state: pointers, valid bits, busy table and the issue register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head        <= '0;
      tail        <= '0;
      valid       <= '0;
      busy        <= '0;
      issue_valid <= 1'b0;
      issue_slot  <= '0;
    end else begin
      issue_valid <= do_issue;
      if (do_issue) begin
        issue_slot <= sel;
        valid[sel] <= 1'b0;
      end
      if (dispatch) begin
        valid[tail] <= 1'b1;
        tail        <= tail + IW'(1);
      end
      if (!valid[head] && (head != tail)) head <= head + IW'(1);
      if (wb_hit) busy[wb_dest] <= 1'b0;
      if (set_dest) busy[d_dest] <= 1'b1;
    end
  end

  // Per-slot source tags and pending bits; only meaningful while valid is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit && (src1[i] == wb_dest)) p1[i] <= 1'b0;
      if (wb_hit && (src2[i] == wb_dest)) p2[i] <= 1'b0;
    end
    if (dispatch) begin
      v1[tail]   <= d_v1;
      p1[tail]   <= d_p1;
      src1[tail] <= d_src1;
      v2[tail]   <= d_v2;
      p2[tail]   <= d_p2;
      src2[tail] <= d_src2;
    end
  end

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Randomized scoreboard bench for iq_issue_ctrl against a slot-array reference model.
module tb_iq_issue_ctrl;

  localparam int D    = 8;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       rst, flush, d_valid, d_v1, d_v2, d_vdest, wb_valid, e_stall;
  logic [4:0] d_src1, d_src2, d_dest, wb_dest;
  logic       d_ready, issue_valid, cheio, vazio;
  logic [2:0] alloc_slot, issue_slot;

  always #5 clk = ~clk;

  iq_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .d_valid     (d_valid),
    .d_v1        (d_v1),
    .d_src1      (d_src1),
    .d_v2        (d_v2),
    .d_src2      (d_src2),
    .d_vdest     (d_vdest),
    .d_dest      (d_dest),
    .d_ready     (d_ready),
    .alloc_slot  (alloc_slot),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .e_stall     (e_stall),
    .issue_valid (issue_valid),
    .issue_slot  (issue_slot),
    .cheio       (cheio),
    .vazio       (vazio)
  );

  typedef struct {
    bit full;
    bit empty;
    bit rdy;
    int alloc;
    bit iv;
    int islot;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   popped = 0;

  // Reference model: one record per slot, a busy flag per register, pointers as ints.
  bit mvalid[D], mv1[D], mp1[D], mv2[D], mp2[D];
  int ms1[D], ms2[D];
  bit mbusy[32];
  int mhead, mtail, mis;
  bit miv;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) mvalid[i] = 1'b0;
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
    mhead = 0;
    mtail = 0;
    miv   = 1'b0;
    mis   = 0;
  endtask

  function automatic bit pend(input bit used, input int s);
    return used && mbusy[s] && !(wb_valid && int'(wb_dest) == s) && (s != 0);
  endfunction

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      popped++;
      check("cheio", int'(cheio), int'(mon_e.full));
      check("vazio", int'(vazio), int'(mon_e.empty));
      check("d_ready", int'(d_ready), int'(mon_e.rdy));
      check("alloc_slot", int'(alloc_slot), mon_e.alloc);
      check("issue_valid", int'(issue_valid), int'(mon_e.iv));
      check("issue_slot", int'(issue_slot), mon_e.islot);
    end
  end

  initial begin
    exp_t e;
    int   mode, sel, idx, nhead;
    bit   found, issue, accept, np1, np2;

    rst = 1'b1; flush = 1'b0; d_valid = 1'b1; d_v1 = 1'b0; d_v2 = 1'b0;
    d_vdest = 1'b0; d_src1 = '0; d_src2 = '0; d_dest = '0;
    wb_valid = 1'b0; wb_dest = '0; e_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Modes: 0 mixed, 1 stall-heavy with no writeback (fills up), 2 drain, 3 flushes.
      mode    = (cyc / 64) % 4;
      rst     = (cyc == 0) || ($urandom_range(499) == 0);
      flush   = (cyc != 0) && (mode == 3) && ($urandom_range(24) == 0);
      d_valid = ($urandom_range(9) < 7);
      d_v1    = 1'($urandom_range(1));
      d_src1  = 5'($urandom_range(7));
      d_v2    = 1'($urandom_range(1));
      d_src2  = 5'($urandom_range(7));
      d_vdest = ($urandom_range(3) != 0);
      d_dest  = 5'($urandom_range(7));
      wb_dest = 5'($urandom_range(7));
      case (mode)
        1:       begin wb_valid = 1'b0; e_stall = ($urandom_range(9) != 0); end
        2:       begin wb_valid = 1'($urandom_range(1)); e_stall = ($urandom_range(9) == 0); end
        default: begin wb_valid = ($urandom_range(3) == 0); e_stall = ($urandom_range(4) == 0); end
      endcase

      e.full = (mhead == mtail) && mvalid[mhead];
      e.empty = 1'b1;
      for (int i = 0; i < D; i++) if (mvalid[i]) e.empty = 1'b0;
      e.rdy   = !e.full && !flush;
      e.alloc = mtail;
      e.iv    = miv;
      e.islot = mis;
      sbq.push_back(e);

      if (rst || flush) begin
        model_clear();
      end else begin
        found = 1'b0;
        sel   = 0;
        for (int a = 0; a < D; a++) begin
          idx = (mhead + a) % D;
          if (!found && mvalid[idx] && !(mv1[idx] && mp1[idx]) && !(mv2[idx] && mp2[idx])) begin
            found = 1'b1;
            sel   = idx;
          end
        end
        issue  = found && !e_stall;
        accept = d_valid && e.rdy;
        np1    = pend(d_v1, int'(d_src1));
        np2    = pend(d_v2, int'(d_src2));
        nhead  = (!mvalid[mhead] && mhead != mtail) ? (mhead + 1) % D : mhead;
        if (wb_valid && wb_dest != 0) begin
          for (int i = 0; i < D; i++) begin
            if (mvalid[i] && mv1[i] && ms1[i] == int'(wb_dest)) mp1[i] = 1'b0;
            if (mvalid[i] && mv2[i] && ms2[i] == int'(wb_dest)) mp2[i] = 1'b0;
          end
          mbusy[wb_dest] = 1'b0;
        end
        if (issue) begin
          mvalid[sel] = 1'b0;
          mis = sel;
        end
        miv = issue;
        if (accept) begin
          mvalid[mtail] = 1'b1;
          mv1[mtail] = d_v1; mp1[mtail] = np1; ms1[mtail] = int'(d_src1);
          mv2[mtail] = d_v2; mp2[mtail] = np2; ms2[mtail] = int'(d_src2);
          if (d_vdest && d_dest != 0) mbusy[d_dest] = 1'b1;
          mtail = (mtail + 1) % D;
        end
        mhead = nhead;
      end

      @(posedge clk);
      #1;
    end

    rst = 1'b0; flush = 1'b0; d_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    check("cycles_checked", popped, NCYC);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
